// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver/transmitter state encoding and frame timing defaults.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } spart_state_e;

    localparam int OVERSAMPLE_DEF  = 16;
    localparam int SAMPLE_PT_DEF   = 7;
    // start + 8 data + stop, shared with the transmitter
    localparam int FRAME_BITS_8N1  = 10;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for the idle-high serial line; resets to 1 so reset never looks like a start bit.
module spart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/spart_rx.sv
// SPART 8N1 receiver, advancing on the 16x r_enable tick; holds one byte plus status flags.
// Define SPART_RX_PARITY_EN to add an even-parity bit between data and stop, reported on parity_err.
module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int SAMPLE_PT  = SAMPLE_PT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r_enable,
    input  logic                 rxd,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun
`ifdef SPART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    logic                 rxd_s;
    spart_state_e         state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 last_tick;
`ifdef SPART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    spart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rxd),
        .q_o (rxd_s)
    );

    assign last_tick = (tick_q == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
`ifdef SPART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = perr_q;
`endif
        // A bus read clears status on any edge; a stop-bit load below takes precedence.
        if (rd_en) begin
            rda_d = 1'b0;
            ovr_d = 1'b0;
        end

        if (r_enable) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TW'(SAMPLE_PT)) begin
                        if (rxd_s) begin
                            state_d = IDLE;
                        end else begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef SPART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`ifdef SPART_RX_PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        par_d   = rxd_s;
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (last_tick) begin
                        rx_data_d = shift_q;
                        ferr_d    = ~rxd_s;
                        ovr_d     = ~rd_en & (ovr_q | rda_q);
                        rda_d     = 1'b1;
`ifdef SPART_RX_PARITY_EN
                        perr_d    = ^{shift_q, par_q};
`endif
                        tick_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef SPART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rda       = rda_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef SPART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: directed and random frames checked against a byte-level status model.
module tb_spart_rx;

`ifdef SPART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int PB    = 1;
`else
    localparam int NBITS = 10;
    localparam int PB    = 0;
`endif
    // clk index (after the tick edge preceding the start bit) of the stop-bit load
    localparam int LOAD_C = 100 + 64 * (8 + PB);

    logic       clk = 1'b0;
    logic       rst;
    logic       r_enable;
    logic       rxd;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rda;
    logic       frame_err;
    logic       overrun;
`ifdef SPART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] m_data;
    logic       m_rda, m_ferr, m_ovr, m_perr;

    spart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .r_enable  (r_enable),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rda       (rda),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef SPART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        r_enable = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            r_enable = 1'b1;
            @(negedge clk);
            r_enable = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rda"},  32'(rda),       32'(m_rda));
        chk({tag, "_data"}, 32'(rx_data),   32'(m_data));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, "_ovr"},  32'(overrun),   32'(m_ovr));
`ifdef SPART_RX_PARITY_EN
        chk({tag, "_perr"}, 32'(parity_err), 32'(m_perr));
`endif
    endtask

    task automatic model_reset();
        m_data = '0; m_rda = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic model_load(input logic [7:0] b, input logic stop, input logic rd_same,
                              input logic bad_par);
        m_ovr  = rd_same ? 1'b0 : (m_ovr | m_rda);
        m_rda  = 1'b1;
        m_data = b;
        m_ferr = ~stop;
        m_perr = bad_par;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_pulse(input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        m_rda = 1'b0;
        m_ovr = 1'b0;
        chk({tag, "_rd_rda"}, 32'(rda),     32'(m_rda));
        chk({tag, "_rd_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic tx_frame(input string tag, input logic [7:0] b, input logic stop,
                            input logic rd_at_load, input logic bad_par);
        logic [10:0] fb;
        fb       = '1;
        fb[0]    = 1'b0;
        fb[8:1]  = b;
`ifdef SPART_RX_PARITY_EN
        fb[9]    = (^b) ^ bad_par;
        fb[10]   = stop;
`else
        fb[9]    = stop;
`endif
        do @(posedge clk); while (!r_enable);
        for (int c = 0; c < NBITS * 64; c++) begin
            @(negedge clk);
            if (c == LOAD_C - 1)
                chk({tag, "_preload_rda"}, 32'(rda), 32'(m_rda));
            if (c == LOAD_C) begin
                model_load(b, stop, rd_at_load, bad_par);
                check_all({tag, "_load"});
            end
            rxd   = fb[c / 64];
            rd_en = rd_at_load && (c == LOAD_C - 1);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop, rrdl;
        rst = 1'b1; rxd = 1'b1; rd_en = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        idle(20);

        tx_frame("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        check_all("a5_end");
        rd_pulse("a5");

        do @(posedge clk); while (!r_enable);
        @(negedge clk);
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        repeat (64) @(negedge clk);
        chk("false_start_rda", 32'(rda), 32'(m_rda));
        tx_frame("3c", 8'h3C, 1'b1, 1'b0, 1'b0);
        check_all("3c_end");
        rd_pulse("3c");

        tx_frame("ferr", 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(80);
        check_all("ferr_end");
        rd_pulse("ferr");

        tx_frame("b2b1", 8'h11, 1'b1, 1'b0, 1'b0);
        tx_frame("b2b2", 8'h22, 1'b1, 1'b0, 1'b0);
        check_all("b2b_end");
        rd_pulse("b2b");

        tx_frame("rdl1", 8'h33, 1'b1, 1'b0, 1'b0);
        tx_frame("rdl2", 8'h44, 1'b1, 1'b1, 1'b0);
        check_all("rdl_end");
        rd_pulse("rdl");

        for (int i = 0; i < 8; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rrdl  = ($urandom_range(0, 3) == 0);
            tx_frame("rnd", rb, rstop, rrdl, 1'b0);
            if (!rstop) idle(80);
            check_all("rnd_end");
            if ($urandom_range(0, 1) == 1) rd_pulse("rnd");
        end

        tx_frame("pre_rst", 8'h96, 1'b1, 1'b0, 1'b0);
        do @(posedge clk); while (!r_enable);
        @(negedge clk);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
        repeat (150) @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        tx_frame("5a", 8'h5A, 1'b1, 1'b0, 1'b0);
        check_all("5a_end");
        rd_pulse("5a");

`ifdef SPART_RX_PARITY_EN
        tx_frame("par_bad", 8'h07, 1'b1, 1'b0, 1'b1);
        check_all("par_bad_end");
        tx_frame("par_ok", 8'h07, 1'b1, 1'b0, 1'b0);
        check_all("par_ok_end");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
